// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, function codes and exception bit positions.
// Used by the issue queue, the ALU and writeback.
package alu_pkg;

    localparam int ALU_W = 20;

    localparam logic [3:0] FN_AND  = 4'd0;
    localparam logic [3:0] FN_OR   = 4'd1;
    localparam logic [3:0] FN_XOR  = 4'd2;
    localparam logic [3:0] FN_ADD  = 4'd3;
    localparam logic [3:0] FN_SUB  = 4'd4;
    localparam logic [3:0] FN_MULT = 4'd5;
    localparam logic [3:0] FN_DIV  = 4'd6;
    localparam logic [3:0] FN_REM  = 4'd7;

    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_DIV0    = 1;

    function automatic logic is_divide(input logic [3:0] func);
        return (func == FN_DIV) || (func == FN_REM);
    endfunction

endpackage

// File: rtl/alu_op_check.sv
// Combinational exception classifier for one ALU op: illegal function code and
// divide/remainder by zero.
module alu_op_check
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] in2,
    output logic [1:0]       exc
);

    always_comb begin
        exc              = '0;
        exc[EXC_ILLEGAL] = (func > FN_REM);
        exc[EXC_DIV0]    = is_divide(func) && (in2 == '0);
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Operand-issue FIFO in front of the ALU with per-entry exception classification.
// Define ALU_ISSUE_BYPASS_EN for zero-latency pass-through when the queue is empty.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_in1,
    input  logic [WIDTH-1:0]           s_in2,
    input  logic [3:0]                 s_func,
    input  logic [TAG_W-1:0]           s_tag,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           alu_in1,
    output logic [WIDTH-1:0]           alu_in2,
    output logic [3:0]                 alu_func,
    output logic [TAG_W-1:0]           m_tag,
    output logic [1:0]                 m_exc,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 exc_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
        logic [3:0]       func;
        logic [TAG_W-1:0] tag;
        logic [1:0]       exc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      exc_cnt_q, exc_cnt_d;

    logic [1:0]      s_exc;
    logic            push;
    logic            fifo_nonempty;
    logic            fifo_pop;
    logic            wr_en;
    logic            bypass_live;
    entry_t          head;

    alu_op_check #(.WIDTH(WIDTH)) u_op_check (
        .func (s_func),
        .in2  (s_in2),
        .exc  (s_exc)
    );

    always_comb begin
        s_ready       = (count_q != CW'(DEPTH)) && !flush;
        push          = s_valid && s_ready;
        fifo_nonempty = (count_q != '0);
`ifdef ALU_ISSUE_BYPASS_EN
        bypass_live   = !fifo_nonempty && s_valid && !flush;
`else
        bypass_live   = 1'b0;
`endif
        head = '0;
        if (bypass_live) begin
            head = '{in1: s_in1, in2: s_in2, func: s_func, tag: s_tag, exc: s_exc};
        end else if (fifo_nonempty) begin
            head = mem_q[rd_ptr_q];
        end
        m_valid  = fifo_nonempty || bypass_live;
        alu_in1  = head.in1;
        alu_in2  = head.in2;
        alu_func = head.func;
        m_tag    = head.tag;
        m_exc    = head.exc;
        count    = count_q;
        exc_cnt  = exc_cnt_q;
        fifo_pop = fifo_nonempty && m_ready;
        // A bypassed op consumed in the same cycle never occupies a slot
        wr_en    = push && !(bypass_live && m_ready);
    end

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        exc_cnt_d = exc_cnt_q;
        if (push && (s_exc != '0) && (exc_cnt_q != 8'hFF)) begin
            exc_cnt_d = exc_cnt_q + 8'd1;
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = '{in1: s_in1, in2: s_in2, func: s_func, tag: s_tag, exc: s_exc};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            exc_cnt_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: scoreboard queue of expected ops, exception
// model, flush, async reset and exc_cnt saturation. Bypass step under ALU_ISSUE_BYPASS_EN.
module tb_alu_issue_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [19:0] in1;
      logic [19:0] in2;
      logic [3:0]  func;
      logic [2:0]  tag;
      logic [1:0]  exc;
   } op_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [19:0] s_in1 = '0;
   logic [19:0] s_in2 = '0;
   logic [3:0]  s_func = '0;
   logic [2:0]  s_tag = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [19:0] alu_in1;
   logic [19:0] alu_in2;
   logic [3:0]  alu_func;
   logic [2:0]  m_tag;
   logic [1:0]  m_exc;
   logic [2:0]  count;
   logic [7:0]  exc_cnt;

   int   checks = 0;
   int   errors = 0;
   op_t  sb[$];
   int   expExcCnt = 0;
   logic bypassBuild;

   alu_issue_queue dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_in1    (s_in1),
      .s_in2    (s_in2),
      .s_func   (s_func),
      .s_tag    (s_tag),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .alu_in1  (alu_in1),
      .alu_in2  (alu_in2),
      .alu_func (alu_func),
      .m_tag    (m_tag),
      .m_exc    (m_exc),
      .count    (count),
      .exc_cnt  (exc_cnt)
   );

   always #5 clk = ~clk;

   // Independent exception model: bit0 illegal code, bit1 DIV/REM by zero
   function automatic logic [1:0] modelExc(input logic [3:0] f, input logic [19:0] b);
      logic [1:0] e;
      e[0] = (f > 4'd7);
      e[1] = ((f == 4'd6) || (f == 4'd7)) && (b == 20'd0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Compares every output against the scoreboard head (or the live op when bypassing)
   task automatic checkOutput(input string step);
      op_t  exp;
      logic expValid;
      logic live;
      live     = bypassBuild && (sb.size() == 0) && s_valid && !flush && !rst;
      expValid = 1'b1;
      if (live) begin
         exp = '{in1: s_in1, in2: s_in2, func: s_func, tag: s_tag, exc: modelExc(s_func, s_in2)};
      end else if (sb.size() != 0) begin
         exp = sb[0];
      end else begin
         exp = '{in1: '0, in2: '0, func: '0, tag: '0, exc: '0};
         expValid = 1'b0;
      end
      chk({step, ".m_valid"},  32'(m_valid),  32'(expValid));
      chk({step, ".s_ready"},  32'(s_ready),  32'((sb.size() != DEPTH) && !flush));
      chk({step, ".count"},    32'(count),    32'(sb.size()));
      chk({step, ".alu_in1"},  32'(alu_in1),  32'(exp.in1));
      chk({step, ".alu_in2"},  32'(alu_in2),  32'(exp.in2));
      chk({step, ".alu_func"}, 32'(alu_func), 32'(exp.func));
      chk({step, ".m_tag"},    32'(m_tag),    32'(exp.tag));
      chk({step, ".m_exc"},    32'(m_exc),    32'(exp.exc));
      chk({step, ".exc_cnt"},  32'(exc_cnt),  32'(expExcCnt));
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model at the edge
   task automatic applyStimulus(input string step, input logic v, input logic [19:0] a,
                                input logic [19:0] b, input logic [3:0] f, input logic [2:0] t,
                                input logic mr, input logic fl);
      logic doPush;
      logic doPop;
      logic live;
      op_t  op;
      @(negedge clk);
      s_valid = v;
      s_in1   = a;
      s_in2   = b;
      s_func  = f;
      s_tag   = t;
      m_ready = mr;
      flush   = fl;
      #1;
      checkOutput(step);
      op     = '{in1: a, in2: b, func: f, tag: t, exc: modelExc(f, b)};
      live   = bypassBuild && (sb.size() == 0) && v && !fl;
      doPush = v && (sb.size() != DEPTH) && !fl;
      doPop  = mr && (sb.size() != 0) && !fl;
      @(posedge clk);
      if (doPush && (op.exc != 2'b00) && (expExcCnt != 255)) expExcCnt++;
      if (fl) begin
         sb.delete();
      end else begin
         if (doPop) void'(sb.pop_front());
         if (doPush && !(live && mr)) sb.push_back(op);
      end
   endtask

   task automatic idle(input string step, input logic mr);
      applyStimulus(step, 1'b0, 20'h0, 20'h0, 4'h0, 3'd0, mr, 1'b0);
   endtask

   initial begin
`ifdef ALU_ISSUE_BYPASS_EN
      bypassBuild = 1'b1;
`else
      bypassBuild = 1'b0;
`endif
      #12;
      checkOutput("reset");
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("push_add", 1'b1, 20'h00005, 20'h00003, 4'd3, 3'd1, 1'b0, 1'b0);
      idle("head_add", 1'b1);
      idle("empty_after_add", 1'b0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus("fill", 1'b1, 20'(i * 17 + 1), 20'(i + 9), 4'(i), 3'(i), 1'b0, 1'b0);
      end
      applyStimulus("full_reject", 1'b1, 20'h12345, 20'h1, 4'd1, 3'd4, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) idle("drain_order", 1'b1);
      idle("drained", 1'b0);

      applyStimulus("push_div0", 1'b1, 20'h00010, 20'h00000, 4'd6, 3'd5, 1'b0, 1'b0);
      applyStimulus("push_illegal", 1'b1, 20'h00020, 20'h00007, 4'hA, 3'd6, 1'b0, 1'b0);
      applyStimulus("push_rem_ok", 1'b1, 20'h00030, 20'h00004, 4'd7, 3'd7, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle("pop_exc", 1'b1);

      applyStimulus("stream_pre0", 1'b1, 20'hAAAAA, 20'h11111, 4'd2, 3'd0, 1'b0, 1'b0);
      applyStimulus("stream_pre1", 1'b1, 20'h55555, 20'h22222, 4'd4, 3'd1, 1'b0, 1'b0);
      for (int i = 2; i < 12; i++) begin
         applyStimulus("stream", 1'b1, 20'(i * 4099), 20'(i * 3), 4'(i % 8), 3'(i), 1'b1, 1'b0);
      end
      idle("stream_drain", 1'b1);
      idle("stream_drain", 1'b1);
      idle("stream_empty", 1'b0);

      for (int i = 0; i < 3; i++) begin
         applyStimulus("prefill", 1'b1, 20'(i + 100), 20'h0, 4'd7, 3'(i), 1'b0, 1'b0);
      end
      applyStimulus("flush", 1'b1, 20'h77777, 20'h0, 4'd6, 3'd3, 1'b1, 1'b1);
      idle("after_flush", 1'b0);

      applyStimulus("pre_rst0", 1'b1, 20'h00101, 20'h00202, 4'd5, 3'd2, 1'b0, 1'b0);
      applyStimulus("pre_rst1", 1'b1, 20'h00303, 20'h00000, 4'd6, 3'd3, 1'b0, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      expExcCnt = 0;
      checkOutput("async_rst");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 260; i++) begin
         applyStimulus("saturate", 1'b1, 20'(i), 20'(i), 4'hF, 3'(i), 1'b1, 1'b0);
      end
      idle("sat_drain", 1'b1);
      idle("sat_final", 1'b0);

`ifdef ALU_ISSUE_BYPASS_EN
      applyStimulus("bypass_consume", 1'b1, 20'd9, 20'd2, 4'd7, 3'd4, 1'b1, 1'b0);
      idle("bypass_after", 1'b0);
      applyStimulus("bypass_hold", 1'b1, 20'd9, 20'd0, 4'd7, 3'd5, 1'b0, 1'b0);
      idle("bypass_queued", 1'b1);
      idle("bypass_empty", 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream operand-issue stage for the 20-bit ALU.
- Accepts decoded operations (two operands, 4-bit function code, tag) from decode over a valid/ready handshake and buffers them in a small circular FIFO.
- Presents the head entry to the ALU's in1/in2/func inputs, with a per-entry exception classification (illegal func, divide-by-zero) computed at enqueue.
- Writeback consumes the head via m_valid/m_ready, alongside the ALU's ans/ZF.

Parameters:
- WIDTH, 20, operand width; must match the ALU datapath.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_W, 3, width of the destination/sequence tag carried with each op.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all queued ops.
- s_valid  in  1  decode offers an op.
- s_ready  out  1  queue can accept.
- s_in1  in  WIDTH  operand 1.
- s_in2  in  WIDTH  operand 2.
- s_func  in  4  function code: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 REM.
- s_tag  in  TAG_W  op tag.
- m_valid  out  1  head op is valid at the ALU inputs.
- m_ready  in  1  writeback consumes the head this cycle.
- alu_in1  out  WIDTH  to ALU in1.
- alu_in2  out  WIDTH  to ALU in2.
- alu_func  out  4  to ALU func.
- m_tag  out  TAG_W  head tag.
- m_exc  out  2  bit0 = illegal func (8..15); bit1 = DIV/REM with in2 == 0.
- count  out  $clog2(DEPTH)+1  occupancy.
- exc_cnt  out  8  saturating count of enqueued ops with any exc bit set.

Behaviour:
- Reset (asynchronous):
  - rd_ptr, wr_ptr, count, exc_cnt = 0.
  - m_valid = 0; s_ready = 1 (unless flush is asserted).
  - alu_in1, alu_in2, alu_func, m_tag, m_exc = 0.
- Storage: registered circular array of {in1, in2, func, tag, exc}. Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Push = s_valid & s_ready. Pop = m_valid & m_ready.
- s_ready = (count != DEPTH) & ~flush. A full queue does not accept, even if a pop occurs in the same cycle; no full pass-through.
- m_valid = (count != 0).
- Head outputs are driven combinationally from array[rd_ptr] when m_valid = 1. When m_valid = 0, all ALU-facing outputs, m_tag and m_exc are forced to 0, giving the ALU the deterministic func 0000.
- Latency: an op accepted at edge N is at the ALU inputs with m_valid = 1 after edge N (one cycle).
- Push and pop in the same cycle: both pointers advance and count is unchanged. Pop from empty and push when full cannot occur by construction.
- exc classification at enqueue:
  - bit0 = (s_func > 7).
  - bit1 = (s_func == 6 or s_func == 7) and (s_in2 == 0).
  - The op is still issued unchanged; writeback decides what to do with it.
- exc_cnt increments on a push with exc != 0 and saturates at 255. It is cleared only by rst; flush does not clear it.
- flush has priority over push and pop. Next cycle: pointers and count = 0, m_valid = 0. s_ready is 0 during the flush cycle.
- Reset mid-operation discards all entries immediately (asynchronous).

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined:
  - When count == 0 and s_valid = 1, the op passes combinationally to the ALU outputs in the same cycle, with m_valid = 1 and exc computed live.
  - If m_ready = 1 in that cycle, the op is consumed and not written into the FIFO; otherwise it is enqueued normally.
  - Zero-cycle latency on an empty queue.
- Undefined: always one-cycle latency as described above.

Decomposition:
- Package alu_pkg:
  - func code localparams (FN_AND .. FN_REM).
  - ALU_W = 20.
  - exc bit indices EXC_ILLEGAL = 0, EXC_DIV0 = 1.
  - shared with the ALU and writeback.
- Sub-module alu_op_check: a purely combinational func/in2 classifier producing exc. It is reused by writeback assertions.

Test Plan:
- Reset, then push {in1=20'h00005, in2=20'h00003, func=3, tag=1} -> next cycle m_valid=1, alu_in1=5, alu_in2=3, alu_func=3, m_tag=1, m_exc=0, count=1.
- Push 4 ops with m_ready=0 -> count=4, s_ready=0. A 5th op offered is not accepted. Then m_ready=1 for 4 cycles -> ops pop in FIFO order (tags 0,1,2,3) and count returns to 0.
- Push func=6, in2=0 -> m_exc=2'b10, exc_cnt=1. Push func=4'hA, in2=7 -> m_exc=2'b01, exc_cnt=2.
- Steady stream with s_valid=m_ready=1 and count=2 -> count stays 2 across 10 cycles, and tags emerge in order across the pointer wrap.
- flush with count=3 while s_valid=1 -> the offered op is not accepted. Next cycle count=0, m_valid=0, alu_func=0, exc_cnt unchanged. Assert rst mid-stream -> outputs zero immediately, without waiting for a clock edge.
- With ALU_ISSUE_BYPASS_EN on an empty queue, push {in1=9, in2=2, func=7} with m_ready=1 -> same-cycle m_valid=1, alu_func=7, and count stays 0.
